// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline stage register with flush and optional skid entry
//
// Purpose:
//   Generic stage register placed between pipeline stages. All control and
//   data fields of a stage boundary travel concatenated in one payload vector.
//   The stage adds stall backpressure, bubble insertion and a synchronous flush.
//
// Configuration macro:
//   PIPE_STAGE_SKID_EN  defined   -> two entries (main + skid); in_ready comes
//                                    straight from registered state, so there
//                                    is no out_ready -> in_ready path.
//                       undefined -> single entry; in_ready depends
//                                    combinationally on out_ready.
//
// Parameters:
//   DATA_W     payload width in bits
//   RST_VAL    payload value loaded on reset
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   flush      synchronous kill of every held entry (beats the handshake)
//   in_valid   upstream entry valid
//   in_ready   stage accepts an entry this cycle
//   in_data    upstream payload
//   out_valid  downstream entry valid (0 = bubble)
//   out_ready  downstream accepts this cycle
//   out_data   registered downstream payload
//   occupancy  number of held entries (0..2)

module pipe_stage #(
    parameter int unsigned        DATA_W  = 104,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // State mirrors occupancy: EMPTY = 0 entries, ONE = main only,
    // TWO = main plus skid (reachable only in the skid build).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q,  skid_d;
`endif

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
    // Ready is decoded from registered state only, which cuts the ready
    // chain between neighbouring stages.
    assign in_ready = (state_q != TWO) && !rst;
`else
    // Single entry: a held entry must leave this cycle for a new one to enter.
    assign in_ready = (!out_valid || out_ready) && !rst;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next-state and payload selection. Payload registers are not touched by
    // flush; their contents are meaningless once out_valid drops.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        // Head leaves while the new entry takes its place.
                        main_d = in_data;
                    end else if (in_fire) begin
`ifdef PIPE_STAGE_SKID_EN
                        // Downstream stalled: park the new entry behind main.
                        state_d = TWO;
                        skid_d  = in_data;
`else
                        // Cannot happen: in_ready already requires out_ready.
                        state_d = ONE;
`endif
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
`ifdef PIPE_STAGE_SKID_EN
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= RST_VAL;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - self-checking bench for pipe_stage against a FIFO queue model

module tb_pipe_stage;

    localparam int unsigned       W       = 104;
    localparam logic [W-1:0]      RST_V   = {W{1'b0}};
`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned       CAP     = 2;
`else
    localparam int unsigned       CAP     = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q[$];
    bit           rst_known;

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(W), .RST_VAL(RST_V)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, check settled outputs
    // against the queue model, then advance the model by the spec's rules.
    task automatic step(input logic r, input logic fl, input logic iv,
                        input logic [W-1:0] id, input logic ordy);
        logic exp_rdy;
        logic exp_ov;
        rst = r; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        #2;
        exp_ov = (q.size() != 0);
        if (r)
            exp_rdy = 1'b0;
        else if (CAP == 2)
            exp_rdy = (q.size() < 2);
        else
            exp_rdy = (q.size() == 0) || ordy;
        chk("in_ready",  W'(in_ready),  W'(exp_rdy));
        chk("out_valid", W'(out_valid), W'(exp_ov));
        chk("occupancy", W'(occupancy), W'(q.size()));
        if (exp_ov)
            chk("out_data", out_data, q[0]);
        else if (rst_known)
            chk("out_data_rst", out_data, RST_V);
        if (r) begin
            q.delete();
            rst_known = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (iv && exp_rdy) begin
                q.push_back(id);
                rst_known = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'(8'hAA); out_ready = 1'b0;
        rst_known = 1'b0;
        @(posedge clk);
        #1;
        rst_known = 1'b1;

        // Reset held with a valid 0xAA offered; nothing may be captured.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, W'(8'hAA), 1'b0);
        step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);

        // Streaming at full rate.
        step(1'b0, 1'b0, 1'b1, W'(1), 1'b1);
        step(1'b0, 1'b0, 1'b1, W'(2), 1'b1);
        step(1'b0, 1'b0, 1'b1, W'(3), 1'b1);
        step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);
        step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);

        // Backpressure: offer 0x10..0x12 while stalled, then drain in order.
        step(1'b0, 1'b0, 1'b1, W'(8'h10), 1'b0);
        step(1'b0, 1'b0, 1'b1, W'(8'h11), 1'b0);
        step(1'b0, 1'b0, 1'b1, W'(8'h12), 1'b0);
        step(1'b0, 1'b0, 1'b1, W'(8'h12), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);

        // Flush while full, with 0x55 offered in the same cycle.
        step(1'b0, 1'b0, 1'b1, W'(8'h20), 1'b0);
        step(1'b0, 1'b0, 1'b1, W'(8'h21), 1'b0);
        step(1'b0, 1'b1, 1'b1, W'(8'h55), 1'b0);
        step(1'b0, 1'b0, 1'b1, W'(8'h66), 1'b0);
        step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);
        step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);

        // Reset while holding an entry.
        step(1'b0, 1'b0, 1'b1, W'(8'h77), 1'b0);
        step(1'b0, 1'b0, 1'b1, W'(8'h78), 1'b0);
        step(1'b1, 1'b0, 1'b1, W'(8'h79), 1'b0);
        step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);

        // Random traffic with rare flushes.
        for (int i = 0; i < 10000; i++) begin
            step(1'b0, ($urandom_range(63) == 0), $urandom_range(1) == 1,
                 rnd_data(), $urandom_range(3) != 0 ? ($urandom_range(1) == 1) : 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, W'(0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
